// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg
//   Shared definitions for the sd-style sequence checker and the matching
//   sequence generator: mode encodings and the next-value function that both
//   sides must agree on.
//
//   seq_next works on a fixed 64-bit container so that it can serve any data
//   width up to 64. Callers zero-extend their operands and truncate the
//   result back to their own width. Truncating the 64-bit sum gives the same
//   result as adding modulo 2^width. Right-shifting a zero-extended word keeps
//   the upper bits clear.
package sd_seq_pkg;

  localparam int SEQ_MAX_W = 64;

  localparam logic SEQ_MODE_INC  = 1'b0;
  localparam logic SEQ_MODE_LFSR = 1'b1;

  // Next expected word after x.
  //   SEQ_MODE_INC : x + step
  //   SEQ_MODE_LFSR: Galois right-shift LFSR with feedback mask tap.
  //                  The all-zero word is a fixed point.
  function automatic logic [SEQ_MAX_W-1:0] seq_next(
    input logic [SEQ_MAX_W-1:0] x,
    input logic                 mode,
    input logic [SEQ_MAX_W-1:0] step,
    input logic [SEQ_MAX_W-1:0] tap
  );
    if (mode == SEQ_MODE_LFSR) begin
      return (x >> 1) ^ (x[0] ? tap : '0);
    end
    return x + step;
  endfunction

endpackage

// File: rtl/sd_drdy_pat.sv
// sd_drdy_pat
//   Pattern-driven handshake throttle. A pointer walks a pat_dep-bit pattern,
//   and the bit under the pointer becomes the next registered ready/valid
//   level. The pointer moves when the current beat completes (srdy & drdy) or
//   while drdy is low. It holds while drdy is high and no word is offered, so
//   an offered ready is never withdrawn before it is used.
//   The checker uses this block to generate c_drdy. A generator can reuse it
//   to throttle srdy.
//
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset (pointer 0, drdy 0)
//     srdy     partner's valid; it only affects the next-state decision
//     pat      throttle pattern; bit i is used when the pointer equals i
//     drdy     registered throttle output
module sd_drdy_pat #(
  parameter int pat_dep = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               srdy,
  input  logic [pat_dep-1:0] pat,
  output logic               drdy
);

  localparam int PTR_W = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  logic [PTR_W-1:0] dpp;
  logic             adv_p0;
  logic [PTR_W-1:0] dpp_nxt_p0;

  always_comb begin
    adv_p0     = (srdy & drdy) | ~drdy;
    dpp_nxt_p0 = (int'(dpp) == pat_dep - 1) ? '0 : dpp + 1'b1;
  end

  // ---- stage p0 -> registered pointer / drdy ----
  // The pattern bit is taken at the pre-advance pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dpp  <= '0;
      drdy <= 1'b0;
    end else if (adv_p0) begin
      drdy <= pat[dpp];
      dpp  <= dpp_nxt_p0;
    end
  end

endmodule

// File: rtl/sd_seq_check_mc.sv
// sd_seq_check_mc
//   Multi-channel srdy/drdy sink checker. Each channel keeps its own last word
//   and a first-word flag. An accepted word is compared against the
//   next-value prediction from the channel's last word. The prediction is
//   either an increment by cfg_step or a Galois LFSR step.
//   Backpressure comes from a drdy pattern. Results are reported through
//   saturating ok/err counters and a capture of the first error.
//
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset
//     c_srdy/c_drdy    consumer handshake; c_drdy is registered
//     c_chan, c_data   channel id and data of the offered word
//     cfg_mode         0 = increment, 1 = LFSR
//     cfg_step         increment for mode 0
//     cfg_resync       on mismatch, adopt the received word as the new base
//     cfg_drdy_pat     drdy throttle pattern
//     cfg_clear        synchronous clear of counters, error capture and first flags
//     ok_cnt, err_cnt  saturating counters of good words and miscompares
//     err_flag         sticky first-error flag
//     err_chan/exp/rcv channel, expected and received word of the first error
module sd_seq_check_mc
  import sd_seq_pkg::*;
#(
  parameter int               width    = 8,
  parameter int               channels = 4,
  parameter int               chan_w   = 2,
  parameter int               pat_dep  = 8,
  parameter int               cnt_w    = 16,
  parameter logic [width-1:0] lfsr_tap = 8'hB8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [chan_w-1:0]  c_chan,
  input  logic [width-1:0]   c_data,
  input  logic               cfg_mode,
  input  logic [width-1:0]   cfg_step,
  input  logic               cfg_resync,
  input  logic [pat_dep-1:0] cfg_drdy_pat,
  input  logic               cfg_clear,
  output logic [cnt_w-1:0]   ok_cnt,
  output logic [cnt_w-1:0]   err_cnt,
  output logic               err_flag,
  output logic [chan_w-1:0]  err_chan,
  output logic [width-1:0]   err_exp,
  output logic [width-1:0]   err_rcv
);

  // Counters stick at all ones instead of wrapping.
  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Per-channel sequence state
  logic [width-1:0] last_q  [channels];
  logic             first_q [channels];

  logic              xfer_p0;
  logic              chan_ok_p0;
  logic [chan_w-1:0] idx_p0;
  logic [width-1:0]  last_p0;
  logic [width-1:0]  exp_p0;
  logic              hit_p0;

  sd_drdy_pat #(
    .pat_dep (pat_dep)
  ) u_drdy (
    .clk     (clk),
    .reset_n (reset_n),
    .srdy    (c_srdy),
    .pat     (cfg_drdy_pat),
    .drdy    (c_drdy)
  );

  // The channel id can address past the last channel when chan_w is wider
  // than needed. The array read is steered to channel 0 in that case. The
  // value read there is ignored because chan_ok_p0 routes the word to the
  // out-of-range error path.
  always_comb begin
    xfer_p0    = c_srdy & c_drdy;
    chan_ok_p0 = int'(c_chan) < channels;
    idx_p0     = chan_ok_p0 ? c_chan : '0;
    last_p0    = last_q[idx_p0];
    exp_p0     = width'(seq_next(SEQ_MAX_W'(last_p0), cfg_mode,
                                 SEQ_MAX_W'(cfg_step), SEQ_MAX_W'(lfsr_tap)));
    hit_p0     = first_q[idx_p0] | (c_data == exp_p0);
  end

  // ---- stage p0 -> registered results / channel state ----
  // cfg_clear wins over a same-cycle transfer: the word is consumed on the
  // bus, but it leaves no trace in the checker. last_q is left alone by the
  // clear because the first flags make the next word a new base anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_cnt   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      err_chan <= '0;
      err_exp  <= '0;
      err_rcv  <= '0;
      for (int i = 0; i < channels; i++) begin
        first_q[i] <= 1'b1;
        last_q[i]  <= '0;
      end
    end else if (cfg_clear) begin
      ok_cnt   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      err_chan <= '0;
      err_exp  <= '0;
      err_rcv  <= '0;
      for (int i = 0; i < channels; i++) begin
        first_q[i] <= 1'b1;
      end
    end else if (xfer_p0) begin
      if (chan_ok_p0) begin
        if (hit_p0) begin
          last_q[idx_p0]  <= c_data;
          first_q[idx_p0] <= 1'b0;
          ok_cnt          <= sat_inc(ok_cnt);
        end else begin
          err_cnt <= sat_inc(err_cnt);
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_chan <= c_chan;
            err_exp  <= exp_p0;
            err_rcv  <= c_data;
          end
          if (cfg_resync) begin
            last_q[idx_p0] <= c_data;
          end
        end
      end else begin
        // The channel id is out of range, so there is no prediction.
        err_cnt <= sat_inc(err_cnt);
        if (!err_flag) begin
          err_flag <= 1'b1;
          err_chan <= c_chan;
          err_exp  <= '0;
          err_rcv  <= c_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_seq_check_mc.sv
// Bench for sd_seq_check_mc. The checker is built with chan_w one bit wider
// than needed, so that out-of-range ids can be offered. It uses cnt_w=4 so
// that counter saturation can be reached quickly.
module tb_sd_seq_check_mc;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int CW  = 3;
  localparam int PD  = 8;
  localparam int CNW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          c_srdy = 1'b0;
  logic          c_drdy;
  logic [CW-1:0] c_chan = '0;
  logic [W-1:0]  c_data = '0;
  logic          cfg_mode = 1'b0;
  logic [W-1:0]  cfg_step = 8'd1;
  logic          cfg_resync = 1'b0;
  logic [PD-1:0] cfg_drdy_pat = 8'hFF;
  logic          cfg_clear = 1'b0;
  logic [CNW-1:0] ok_cnt, err_cnt;
  logic          err_flag;
  logic [CW-1:0] err_chan;
  logic [W-1:0]  err_exp, err_rcv;

  always #5 clk = ~clk;

  sd_seq_check_mc #(
    .width(W), .channels(CH), .chan_w(CW), .pat_dep(PD), .cnt_w(CNW), .lfsr_tap(8'hB8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy), .c_drdy(c_drdy),
    .c_chan(c_chan), .c_data(c_data), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
    .cfg_resync(cfg_resync), .cfg_drdy_pat(cfg_drdy_pat), .cfg_clear(cfg_clear),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
    .err_chan(err_chan), .err_exp(err_exp), .err_rcv(err_rcv)
  );

  typedef struct {
    int ok; int err; int flag; int chan; int eexp; int ercv;
  } res_t;

  typedef struct {
    bit clr; logic mode; int step; logic rs; int chan; int data; res_t r;
  } vec_t;

  vec_t vecs[$];
  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t mk(int ok, int err, int flag, int chan, int eexp, int ercv);
    res_t r;
    r.ok = ok; r.err = err; r.flag = flag; r.chan = chan; r.eexp = eexp; r.ercv = ercv;
    return r;
  endfunction

  function automatic vec_t mv(bit clr, logic mode, int step, logic rs, int chan, int data, res_t r);
    vec_t v;
    v.clr = clr; v.mode = mode; v.step = step; v.rs = rs; v.chan = chan; v.data = data; v.r = r;
    return v;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_res(string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got ok=%0d expected an entry", tag, ok_cnt);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".ok_cnt"},   int'(ok_cnt),   e.ok);
    chk({tag, ".err_cnt"},  int'(err_cnt),  e.err);
    chk({tag, ".err_flag"}, int'(err_flag), e.flag);
    chk({tag, ".err_chan"}, int'(err_chan), e.chan);
    chk({tag, ".err_exp"},  int'(err_exp),  e.eexp);
    chk({tag, ".err_rcv"},  int'(err_rcv),  e.ercv);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".c_drdy"},   int'(c_drdy),   0);
    chk({tag, ".ok_cnt"},   int'(ok_cnt),   0);
    chk({tag, ".err_cnt"},  int'(err_cnt),  0);
    chk({tag, ".err_flag"}, int'(err_flag), 0);
    chk({tag, ".err_chan"}, int'(err_chan), 0);
    chk({tag, ".err_exp"},  int'(err_exp),  0);
    chk({tag, ".err_rcv"},  int'(err_rcv),  0);
  endtask

  // Offer one word and wait (bounded) until it is taken. Returns #1 after
  // the accepting edge.
  task automatic send(int chan, int data);
    bit rdy;
    bit done;
    done   = 1'b0;
    c_chan = CW'(chan);
    c_data = W'(data);
    c_srdy = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = c_drdy;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    c_srdy = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ch %0d data 0x%0h not taken, got no drdy, expected drdy within 40 cycles", chan, data);
    end
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int xf;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drdy_all_ones", int'(c_drdy), 1);

    // clr, mode, step, resync, chan, data, expected {ok, err, flag, chan, exp, rcv}
    vecs.push_back(mv(1, 0, 1, 0, 0, 5,    mk(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 1, 0, 2, 9,    mk(2, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 1, 0, 0, 6,    mk(3, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 1, 0, 2, 10,   mk(4, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 1, 0, 0, 7,    mk(5, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 3, 0, 1, 0,    mk(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 3, 0, 1, 3,    mk(2, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 3, 0, 1, 7,    mk(2, 1, 1, 1, 6, 7)));
    vecs.push_back(mv(0, 0, 3, 0, 1, 10,   mk(2, 2, 1, 1, 6, 7)));
    vecs.push_back(mv(1, 0, 3, 1, 1, 0,    mk(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 3, 1, 1, 3,    mk(2, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 3, 1, 1, 7,    mk(2, 1, 1, 1, 6, 7)));
    vecs.push_back(mv(0, 0, 3, 1, 1, 10,   mk(3, 1, 1, 1, 6, 7)));
    vecs.push_back(mv(1, 1, 0, 0, 0, 8'h01, mk(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 1, 0, 0, 0, 8'hB8, mk(2, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 1, 0, 0, 0, 8'h5C, mk(3, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 1, 0, 0, 0, 8'h00, mk(3, 1, 1, 0, 8'h2E, 8'h00)));
    vecs.push_back(mv(0, 0, 4, 0, 0, 8'h60, mk(4, 1, 1, 0, 8'h2E, 8'h00)));
    vecs.push_back(mv(1, 0, 1, 0, 5, 8'h33, mk(0, 1, 1, 5, 0, 8'h33)));
    vecs.push_back(mv(0, 0, 1, 0, 0, 8'h40, mk(1, 1, 1, 5, 0, 8'h33)));

    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      cfg_mode   = vecs[i].mode;
      cfg_step   = W'(vecs[i].step);
      cfg_resync = vecs[i].rs;
      sb_q.push_back(vecs[i].r);
      send(vecs[i].chan, vecs[i].data);
      chk_res($sformatf("vec%0d", i));
    end

    // Alternating drdy pattern with srdy held high
    reset_n = 1'b0;
    cfg_drdy_pat = 8'b1010_1010;
    cfg_mode = 1'b0; cfg_step = 8'd1; cfg_resync = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    c_chan = '0; c_data = 8'h10; c_srdy = 1'b1;
    xf = 0;
    for (int k = 1; k <= 17; k++) begin
      bit rdy;
      rdy = c_drdy;
      @(posedge clk);
      #1;
      if (rdy) begin
        xf++;
        c_data = c_data + 8'd1;
      end
      chk($sformatf("pat_drdy_edge%0d", k), int'(c_drdy), (k >= 2 && (k % 2) == 0) ? 1 : 0);
    end
    c_srdy = 1'b0;
    chk("pat_xfers", xf, 8);
    chk("pat_ok_cnt", int'(ok_cnt), 8);
    chk("pat_err_cnt", int'(err_cnt), 0);
    cfg_drdy_pat = 8'hFF;

    // cfg_clear coinciding with a bad word
    do_clear();
    send(0, 1);
    send(0, 2);
    chk("clr_pre_ok", int'(ok_cnt), 2);
    chk("clr_drdy_ready", int'(c_drdy), 1);
    c_chan = '0; c_data = 8'd9; c_srdy = 1'b1; cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    c_srdy = 1'b0; cfg_clear = 1'b0;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
    chk_res("clr_xfer");
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0));
    send(0, 50);
    chk_res("clr_after");

    // Saturation and asynchronous reset mid-stream
    do_clear();
    for (int i = 0; i < 20; i++) send(1, 100 + i);
    chk("sat_ok_cnt", int'(ok_cnt), 15);
    chk("sat_ok_err", int'(err_cnt), 0);
    for (int i = 0; i < 20; i++) send(1, 0);
    sb_q.push_back(mk(15, 15, 1, 1, 8'h78, 8'h00));
    chk_res("sat_err");
    c_chan = 3'd1; c_data = 8'd0; c_srdy = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    c_srdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_seq_check_mc.md
Name: sd_seq_check_mc

Overview:
Parametrised multi-channel srdy/drdy traffic checker for testbench sinks. It checks a per-channel data sequence in one of two modes: step increment or Galois LFSR. Backpressure comes from a drdy pattern driven on a port, and results are reported as saturating counters plus a first-error capture. It sits at the consumer end of any sd-style block under test and supersedes the single-channel, fixed-increment checker.

Parameters:
width, 8, data width in bits
channels, 4, number of independent sequences (1..256)
chan_w, 2, channel id width; must be at least clog2(channels) and at least 1
pat_dep, 8, drdy pattern length in bits
cnt_w, 16, width of ok/err counters
lfsr_tap, 8'hB8, Galois feedback mask for LFSR mode (width bits)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
c_srdy  in  1  producer valid
c_drdy  out  1  consumer ready (registered)
c_chan  in  chan_w  channel id of the current word
c_data  in  width  data word
cfg_mode  in  1  0 = increment by cfg_step, 1 = LFSR
cfg_step  in  width  increment value for mode 0
cfg_resync  in  1  1 = on mismatch, adopt the received word as the new sequence base
cfg_drdy_pat  in  pat_dep  drdy pattern (bit i is used at pointer i)
cfg_clear  in  1  synchronous clear of all checker state
ok_cnt  out  cnt_w  accepted in-sequence words
err_cnt  out  cnt_w  miscompares
err_flag  out  1  sticky first-error indicator
err_chan  out  chan_w  channel of the first error
err_exp  out  width  expected value at the first error
err_rcv  out  width  received value at the first error

Behaviour:
- Reset (reset_n low, asynchronous): c_drdy=0, pattern pointer dpp=0, every first[ch]=1, every last[ch]=0, ok_cnt=0, err_cnt=0, err_flag=0, err_chan/err_exp/err_rcv=0.
- Transfer: xfer = c_srdy & c_drdy, evaluated at posedge clk.
- drdy generator:
  - dpp advances mod pat_dep when xfer or !c_drdy; otherwise it holds.
  - When dpp advances, c_drdy next = cfg_drdy_pat[dpp], using the pre-advance dpp. When dpp holds (c_drdy=1, c_srdy=0), c_drdy holds.
  - c_drdy never depends combinationally on c_srdy.
  - With cfg_drdy_pat all ones, c_drdy is 1 from the second clock after reset release onward.
- Next-value function nv(x):
  - mode 0: (x + cfg_step) mod 2^width.
  - mode 1: (x >> 1) ^ (x[0] ? lfsr_tap : 0). Zero maps to zero.
- On xfer with c_chan < channels:
  - exp = nv(last[c_chan]).
  - If first[c_chan]=1 or c_data == exp: last <= c_data, first <= 0, ok_cnt += 1.
  - Otherwise: err_cnt += 1. If err_flag=0, capture err_chan/err_exp/err_rcv and set err_flag. If cfg_resync=1, last <= c_data; otherwise last is unchanged.
- On xfer with c_chan >= channels: err_cnt += 1; capture with err_exp=0 if this is the first error; no channel state changes.
- Counters saturate at all ones and do not wrap.
- Only the addressed channel updates; the other channels are untouched.
- cfg_clear=1: next cycle, counters, err_* outputs and err_flag are 0 and all first[ch]=1. cfg_clear has priority over a same-cycle xfer: the word is accepted on the bus but not checked or counted. dpp and c_drdy are unaffected by cfg_clear.
- Changing cfg_mode or cfg_step mid-stream takes effect on the next compare; there is no implicit resync.
- Result outputs are registered; each takes effect one cycle after the triggering xfer.
- Reset asserted mid-transfer: all state returns to reset values immediately; the in-flight word is discarded.

Decomposition:
- Shared package sd_seq_pkg:
  - mode constants SEQ_MODE_INC=1'b0, SEQ_MODE_LFSR=1'b1.
  - function seq_next(x, mode, step, tap), also used by the sequence generator.
- One sub-module, sd_drdy_pat: pattern pointer plus registered c_drdy, with ports clk, reset_n, srdy, pat, drdy. It is reused by the generator side for srdy throttling.
- Per-channel last/first state: a register array inside sd_seq_check_mc.

Test Plan:
1. Mode 0, step 1, channels=4, pattern 8'hFF. Send ch0 data 5,6,7 and ch2 data 9,10 interleaved. Expect ok_cnt=5, err_cnt=0, err_flag=0.
2. Mode 0, step 3. Send ch1 data 0,3,7,10 with cfg_resync=0. Expect err_cnt=2 (7 vs 6, then 10 vs 6), ok_cnt=2, err_chan=1, err_exp=6, err_rcv=7. Repeat with cfg_resync=1: expect err_cnt=1, ok_cnt=3.
3. Mode 1, tap 8'hB8. Send seed 8'h01, then 8'hB8, then 8'h5C. Expect ok_cnt=3. Next send 8'h00 (expected 8'h2E): expect err_exp=8'h2E, err_rcv=8'h00.
4. Pattern 8'b1010_1010, c_srdy held at 1 for 16 cycles. Expect c_drdy to alternate 0/1 after the first post-reset cycle, 8 transfers, dpp wrapping cleanly at 8.
5. cfg_clear asserted in the same cycle as an xfer of a wrong value on ch0. Expect err_cnt=0 and err_flag=0 next cycle. The next ch0 word is accepted as a new first word and ok_cnt=1.
6. cnt_w=4: 20 good words give ok_cnt=15 (saturated). Pull reset_n low mid-stream with c_srdy=1: expect c_drdy=0 and all outputs 0 asynchronously.
